// File: rtl/trg_sci_pkt_rx_if.sv
// Trigger sci-data FIFO read port between the FIFO (master) and the packet receiver (slave).
interface trg_sci_pkt_rx_if;
  logic [7:0] fifo_data_in;
  logic       fifo_empty_in;
  logic       fifo_rd_out;

  modport master (output fifo_data_in, output fifo_empty_in, input fifo_rd_out);
  modport slave  (input fifo_data_in, input fifo_empty_in, output fifo_rd_out);
endinterface

// File: rtl/trg_sci_pkt_rx.sv
// Trigger science packet receiver: hunts 0xEB90, captures 20-byte packets, checks CRC-16, decodes fields.
// Optional TRG_SCI_PKT_SEQ_CHECK_EN adds an eff_trg_cnt sequence check (seq_err_out, seq_err_cnt_out).
module trg_sci_pkt_rx #(
  parameter logic [15:0] CRC_POLY    = 16'h1021,
  parameter logic [15:0] CRC_INIT    = 16'hFFFF,
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  trg_sci_pkt_rx_if.slave        fifo,
  input  logic                   rx_enb_in,
  output logic                   pkt_valid_out,
  output logic                   crc_err_out,
  output logic                   timeout_err_out,
  output logic [15:0]            logic_grp_sel_out,
  output logic [15:0]            hit_sig_stus_out,
  output logic [15:0]            eff_trg_cnt_out,
  output logic [23:0]            trg_busy_time_out,
  output logic [7:0]             trg_delay_timer_out,
  output logic [15:0]            pkt_ok_cnt_out,
  output logic [15:0]            crc_err_cnt_out
`ifdef TRG_SCI_PKT_SEQ_CHECK_EN
  ,
  output logic                   seq_err_out,
  output logic [15:0]            seq_err_cnt_out
`endif
);

  localparam int unsigned GAP_W  = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;
  localparam int unsigned BCNT_W = 5;

  typedef enum logic [1:0] {HUNT0, HUNT1, BODY, CHECK} state_t;

  state_t              state, state_nxt;
  logic                rd_d1;
  logic [7:0]          rx_byte;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [15:0]         crc_calc;
  logic [15:0]         sh_lgs, sh_hit, sh_eff;
  logic [23:0]         sh_busy;
  logic [7:0]          sh_dly, rx_crc_hi;
  logic                gap_expire_c, last_byte_c, crc_ok_c, in_pkt_c;

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  assign rx_byte          = fifo.fifo_data_in;
  assign fifo.fifo_rd_out = !rst_in && !fifo.fifo_empty_in && rx_enb_in && (state != CHECK);

  // Next state; a byte landing during CHECK is already the first byte of the next packet.
  always_comb begin
    state_nxt    = state;
    in_pkt_c     = (state == HUNT1) || (state == BODY);
    gap_expire_c = in_pkt_c && !rd_d1 && (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
    last_byte_c  = (state == BODY) && rd_d1 && (byte_cnt == BCNT_W'(19));
    crc_ok_c     = (crc_calc == {rx_crc_hi, rx_byte});
    case (state)
      HUNT0: if (rd_d1 && rx_byte == 8'hEB) state_nxt = HUNT1;
      HUNT1: begin
        if (rd_d1) begin
          if (rx_byte == 8'h90)      state_nxt = BODY;
          else if (rx_byte != 8'hEB) state_nxt = HUNT0;
        end else if (gap_expire_c) begin
          state_nxt = HUNT0;
        end
      end
      BODY: begin
        if (last_byte_c)       state_nxt = CHECK;
        else if (gap_expire_c) state_nxt = HUNT0;
      end
      CHECK: state_nxt = (rd_d1 && rx_byte == 8'hEB) ? HUNT1 : HUNT0;
      default: state_nxt = HUNT0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= HUNT0;
      rd_d1               <= 1'b0;
      byte_cnt            <= '0;
      gap_cnt             <= '0;
      crc_calc            <= '0;
      sh_lgs              <= '0;
      sh_hit              <= '0;
      sh_eff              <= '0;
      sh_busy             <= '0;
      sh_dly              <= '0;
      rx_crc_hi           <= '0;
      pkt_valid_out       <= 1'b0;
      crc_err_out         <= 1'b0;
      timeout_err_out     <= 1'b0;
      logic_grp_sel_out   <= '0;
      hit_sig_stus_out    <= '0;
      eff_trg_cnt_out     <= '0;
      trg_busy_time_out   <= '0;
      trg_delay_timer_out <= '0;
      pkt_ok_cnt_out      <= '0;
      crc_err_cnt_out     <= '0;
    end else begin
      state           <= state_nxt;
      rd_d1           <= fifo.fifo_rd_out;
      pkt_valid_out   <= 1'b0;
      crc_err_out     <= 1'b0;
      timeout_err_out <= gap_expire_c;

      if (gap_expire_c || rd_d1 || !in_pkt_c) gap_cnt <= '0;
      else                                    gap_cnt <= gap_cnt + GAP_W'(1);

      if (state == HUNT1 && rd_d1 && rx_byte == 8'h90) begin
        byte_cnt <= BCNT_W'(2);
        crc_calc <= CRC_INIT;
      end

      // Body bytes: CRC over 2..17, stage only the bytes that carry fields or the CRC.
      if (state == BODY && rd_d1) begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
        if (byte_cnt <= BCNT_W'(17)) crc_calc <= crc_byte(crc_calc, rx_byte);
        case (byte_cnt)
          BCNT_W'(4):  sh_lgs[15:8]   <= rx_byte;
          BCNT_W'(5):  sh_lgs[7:0]    <= rx_byte;
          BCNT_W'(6):  sh_hit[15:8]   <= rx_byte;
          BCNT_W'(7):  sh_hit[7:0]    <= rx_byte;
          BCNT_W'(10): sh_eff[15:8]   <= rx_byte;
          BCNT_W'(11): sh_eff[7:0]    <= rx_byte;
          BCNT_W'(12): sh_busy[23:16] <= rx_byte;
          BCNT_W'(13): sh_busy[15:8]  <= rx_byte;
          BCNT_W'(14): sh_busy[7:0]   <= rx_byte;
          BCNT_W'(15): sh_dly         <= rx_byte;
          BCNT_W'(18): rx_crc_hi      <= rx_byte;
          default: ;
        endcase
      end

      if (last_byte_c) begin
        if (crc_ok_c) begin
          pkt_valid_out       <= 1'b1;
          logic_grp_sel_out   <= sh_lgs;
          hit_sig_stus_out    <= sh_hit;
          eff_trg_cnt_out     <= sh_eff;
          trg_busy_time_out   <= sh_busy;
          trg_delay_timer_out <= sh_dly;
          if (pkt_ok_cnt_out != 16'hFFFF) pkt_ok_cnt_out <= pkt_ok_cnt_out + 16'd1;
        end else begin
          crc_err_out <= 1'b1;
          if (crc_err_cnt_out != 16'hFFFF) crc_err_cnt_out <= crc_err_cnt_out + 16'd1;
        end
      end
    end
  end

`ifdef TRG_SCI_PKT_SEQ_CHECK_EN
  logic [15:0] prev_eff;
  logic        have_prev;

  // Sequence check against the previous good packet; first good packet after reset only seeds it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_eff        <= '0;
      have_prev       <= 1'b0;
      seq_err_out     <= 1'b0;
      seq_err_cnt_out <= '0;
    end else begin
      seq_err_out <= 1'b0;
      if (last_byte_c && crc_ok_c) begin
        prev_eff  <= sh_eff;
        have_prev <= 1'b1;
        if (have_prev && sh_eff != prev_eff + 16'd1) begin
          seq_err_out <= 1'b1;
          if (seq_err_cnt_out != 16'hFFFF) seq_err_cnt_out <= seq_err_cnt_out + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_trg_sci_pkt_rx.sv
// Scoreboard bench for trg_sci_pkt_rx: FIFO model feeds packets, a monitor compares every event pulse.
module tb_trg_sci_pkt_rx;
  localparam int unsigned GAP_TIMEOUT = 1024;

  typedef struct {
    logic [2:0]  kind;   // {pkt_valid, crc_err, timeout_err}
    logic [15:0] lgs, hit, eff;
    logic [23:0] busy;
    logic [7:0]  dly;
    logic [15:0] okc, crcc, seqc;
    logic        seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_enb = 1'b0;

  logic        pv, ce, to;
  logic [15:0] lgs, hit, eff, okc, crcc;
  logic [23:0] busy;
  logic [7:0]  dly;
  logic        seq_err;
  logic [15:0] seq_cnt;

  trg_sci_pkt_rx_if ifc ();

  trg_sci_pkt_rx #(.GAP_TIMEOUT(GAP_TIMEOUT)) dut (
    .clk_in(clk), .rst_in(rst), .fifo(ifc), .rx_enb_in(rx_enb),
    .pkt_valid_out(pv), .crc_err_out(ce), .timeout_err_out(to),
    .logic_grp_sel_out(lgs), .hit_sig_stus_out(hit), .eff_trg_cnt_out(eff),
    .trg_busy_time_out(busy), .trg_delay_timer_out(dly),
    .pkt_ok_cnt_out(okc), .crc_err_cnt_out(crcc)
`ifdef TRG_SCI_PKT_SEQ_CHECK_EN
    , .seq_err_out(seq_err), .seq_err_cnt_out(seq_cnt)
`endif
  );

`ifndef TRG_SCI_PKT_SEQ_CHECK_EN
  assign seq_err = 1'b0;
  assign seq_cnt = 16'h0000;
`endif

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  exp_t       sb[$];
  bit         toggle_mode = 1'b0;
  int         fifo_n;
  int         bad_reads = 0;
  int         cyc = 0;
  int         last_rd_cyc = 0;
  int         pv_cyc = 0;

  // Reference model state
  logic [15:0] m_lgs = '0, m_hit = '0, m_eff = '0, m_ok = '0, m_crc = '0, m_seqc = '0, m_prev = '0;
  logic [23:0] m_busy = '0;
  logic [7:0]  m_dly = '0;
  bit          m_have = 1'b0;

  // FIFO model: registered empty flag, data valid the cycle after a read
  always @(posedge clk) begin
    fifo_n = q.size();
    if (ifc.fifo_rd_out) begin
      last_rd_cyc = cyc;
      if (ifc.fifo_empty_in || fifo_n == 0) bad_reads++;
      if (fifo_n > 0) begin
        ifc.fifo_data_in <= q.pop_front();
        fifo_n--;
      end
    end
    ifc.fifo_empty_in <= (fifo_n == 0) || (toggle_mode && !ifc.fifo_empty_in);
    cyc++;
  end

  // Scoreboard monitor
  exp_t me;
  always @(negedge clk) begin
    if (!rst && (pv || ce || to)) begin
      if (pv) pv_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got={pv,ce,to}=%b required=none", {pv, ce, to});
      end else begin
        me = sb.pop_front();
        if ({pv, ce, to} !== me.kind) begin
          errors++;
          $display("FAIL event_kind got=%b required=%b", {pv, ce, to}, me.kind);
        end
        checks++;
        if ({lgs, hit, eff, busy, dly} !== {me.lgs, me.hit, me.eff, me.busy, me.dly}) begin
          errors++;
          $display("FAIL fields got=%h_%h_%h_%h_%h required=%h_%h_%h_%h_%h",
                   lgs, hit, eff, busy, dly, me.lgs, me.hit, me.eff, me.busy, me.dly);
        end
        checks++;
        if ({okc, crcc} !== {me.okc, me.crcc}) begin
          errors++;
          $display("FAIL counters got ok=%0d crc=%0d required ok=%0d crc=%0d", okc, crcc, me.okc, me.crcc);
        end
`ifdef TRG_SCI_PKT_SEQ_CHECK_EN
        checks++;
        if ({seq_err, seq_cnt} !== {me.seq, me.seqc}) begin
          errors++;
          $display("FAIL seq got err=%b cnt=%0d required err=%b cnt=%0d", seq_err, seq_cnt, me.seq, me.seqc);
        end
`endif
      end
    end
  end

  function automatic logic [15:0] model_crc(input logic [7:0] b [20]);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 2; k <= 17; k++) begin
      c = c ^ {b[k], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic push_pkt(input logic [15:0] p_lgs, input logic [15:0] p_hit, input logic [15:0] p_eff,
                          input logic [23:0] p_busy, input logic [7:0] p_dly, input bit corrupt,
                          input int nbytes, input bit expect_evt);
    logic [7:0]  b [20];
    logic [15:0] c;
    exp_t        e;
    b[0] = 8'hEB;  b[1] = 8'h90;
    b[2] = 8'($urandom_range(0, 255));  b[3] = 8'($urandom_range(0, 255));
    b[4] = p_lgs[15:8];  b[5] = p_lgs[7:0];
    b[6] = p_hit[15:8];  b[7] = p_hit[7:0];
    b[8] = 8'($urandom_range(0, 255));  b[9] = 8'($urandom_range(0, 255));
    b[10] = p_eff[15:8]; b[11] = p_eff[7:0];
    b[12] = p_busy[23:16]; b[13] = p_busy[15:8]; b[14] = p_busy[7:0];
    b[15] = p_dly;
    b[16] = 8'($urandom_range(0, 255)); b[17] = 8'($urandom_range(0, 255));
    c = model_crc(b);
    b[18] = c[15:8];
    b[19] = c[7:0] ^ (corrupt ? 8'h01 : 8'h00);
    for (int k = 0; k < nbytes; k++) q.push_back(b[k]);
    if (!expect_evt) return;
    e.seq = 1'b0;
    if (nbytes < 20) begin
      e.kind = 3'b001;
    end else if (corrupt) begin
      e.kind = 3'b010;
      if (m_crc != 16'hFFFF) m_crc++;
    end else begin
      e.kind = 3'b100;
      if (m_ok != 16'hFFFF) m_ok++;
      m_lgs = p_lgs; m_hit = p_hit; m_eff = p_eff; m_busy = p_busy; m_dly = p_dly;
`ifdef TRG_SCI_PKT_SEQ_CHECK_EN
      e.seq = m_have && (p_eff != 16'(m_prev + 16'd1));
      if (e.seq && m_seqc != 16'hFFFF) m_seqc++;
      m_prev = p_eff;
      m_have = 1'b1;
`endif
    end
    e.lgs = m_lgs; e.hit = m_hit; e.eff = m_eff; e.busy = m_busy; e.dly = m_dly;
    e.okc = m_ok; e.crcc = m_crc; e.seqc = m_seqc;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain pending_events=%0d required=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic model_reset();
    m_lgs = '0; m_hit = '0; m_eff = '0; m_busy = '0; m_dly = '0;
    m_ok = '0; m_crc = '0; m_seqc = '0; m_prev = '0; m_have = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({pv, ce, to, lgs, hit, eff, busy, dly, okc, crcc, seq_err, seq_cnt, ifc.fifo_rd_out} !== '0) begin
      errors++;
      $display("FAIL reset_state got nonzero outputs ok=%0d crc=%0d lgs=%h rd=%b required all 0",
               okc, crcc, lgs, ifc.fifo_rd_out);
    end
    rst = 1'b0;
    rx_enb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good();
    push_pkt(16'h8005, 16'h1234, 16'h002A, 24'h010203, 8'h07, 1'b0, 20, 1'b1);
    wait_idle(200, "good");
    checks++;
    if (okc !== 16'd1) begin
      errors++;
      $display("FAIL good_ok_cnt got=%0d required=1", okc);
    end
    checks++;
    if (pv_cyc - last_rd_cyc != 2) begin
      errors++;
      $display("FAIL good_latency got=%0d required=2", pv_cyc - last_rd_cyc);
    end
  endtask

  task automatic test_crc_error();
    push_pkt(16'h8005, 16'h1234, 16'h002A, 24'h010203, 8'h07, 1'b1, 20, 1'b1);
    wait_idle(200, "crc");
    checks++;
    if ({crcc, lgs} !== {16'd1, 16'h8005}) begin
      errors++;
      $display("FAIL crc_err_cnt got cnt=%0d lgs=%h required cnt=1 lgs=8005", crcc, lgs);
    end
  endtask

  task automatic test_header_hunt();
    q.push_back(8'h55);
    q.push_back(8'hEB);
    push_pkt(16'h4321, 16'hBEEF, 16'h002B, 24'hFEDCBA, 8'h3C, 1'b0, 20, 1'b1);
    wait_idle(200, "hunt");
  endtask

  task automatic test_gap_timeout();
    push_pkt(16'hDEAD, 16'hCAFE, 16'h7777, 24'h555555, 8'h99, 1'b0, 10, 1'b1);
    wait_idle(GAP_TIMEOUT + 200, "gap");
    push_pkt(16'h0A0B, 16'h0C0D, 16'h002C, 24'h0E0F10, 8'h12, 1'b0, 20, 1'b1);
    wait_idle(200, "gap_recover");
  endtask

  task automatic test_empty_enable();
    int  sz;
    bit  reached = 1'b0;
    toggle_mode = 1'b1;
    push_pkt(16'h0F0F, 16'hA5A5, 16'h002D, 24'hABCDEF, 8'h11, 1'b0, 20, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() <= 12) begin
        reached = 1'b1;
        break;
      end
    end
    rx_enb = 1'b0;
    repeat (3) @(negedge clk);
    sz = q.size();
    repeat (50) @(negedge clk);
    checks++;
    if (!reached || q.size() != sz) begin
      errors++;
      $display("FAIL enb_hold got remaining=%0d required=%0d", q.size(), sz);
    end
    rx_enb = 1'b1;
    wait_idle(400, "enable");
    toggle_mode = 1'b0;
    checks++;
    if (bad_reads != 0) begin
      errors++;
      $display("FAIL read_while_empty got=%0d required=0", bad_reads);
    end
  endtask

  task automatic test_reset_mid_packet();
    push_pkt(16'h1111, 16'h2222, 16'h3333, 24'h444444, 8'h55, 1'b0, 13, 1'b0);
    wait_idle(200, "partial");
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pv, ce, to, lgs, hit, eff, busy, dly, okc, crcc, seq_err, seq_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid got ok=%0d crc=%0d lgs=%h eff=%h required all 0", okc, crcc, lgs, eff);
    end
    push_pkt(16'h1357, 16'h2468, 16'h0005, 24'h0000FF, 8'h01, 1'b0, 20, 1'b1);
    wait_idle(200, "post_reset");
    checks++;
    if (okc !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_ok_cnt got=%0d required=1", okc);
    end
  endtask

  task automatic test_back_to_back();
    push_pkt(16'hAAAA, 16'h5555, 16'h0006, 24'h123456, 8'h20, 1'b0, 20, 1'b1);
    push_pkt(16'hBBBB, 16'h6666, 16'h0008, 24'h654321, 8'h21, 1'b0, 20, 1'b1);
    wait_idle(300, "b2b");
    checks++;
    if (okc !== 16'd3) begin
      errors++;
      $display("FAIL b2b_ok_cnt got=%0d required=3", okc);
    end
`ifdef TRG_SCI_PKT_SEQ_CHECK_EN
    checks++;
    if (seq_cnt !== 16'd1) begin
      errors++;
      $display("FAIL seq_err_cnt got=%0d required=1", seq_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc_error();
    test_header_hunt();
    test_gap_timeout();
    test_empty_enable();
    test_reset_mid_packet();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
